// File: rtl/game_state_engine.sv
// Per-frame dinosaur-runner game logic: jump physics, obstacle scroll/respawn,
// collision, score, night toggle and the IDLE/RUN/OVER state machine.
module game_state_engine #(
    parameter int unsigned GROUND_Y     = 200,
    parameter int unsigned DINO_X       = 40,
    parameter int unsigned JUMP_V       = 10,
    parameter int unsigned GRAVITY      = 1,
    parameter int unsigned OBS_START_X  = 340,
    parameter int unsigned SPEED_INIT   = 2,
    parameter int unsigned SPEED_MAX    = 6,
    parameter int unsigned SPEED_STEP   = 8,
    parameter int unsigned NIGHT_PERIOD = 16,
    parameter int unsigned ANIM_FRAMES  = 6,
    parameter int unsigned HIT_DX       = 12,
    parameter int unsigned HIT_DY       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        jump_btn,
    output logic [11:0] dino_y,
    output logic [1:0]  dino_state,
    output logic [11:0] obstacle_x,
    output logic        night,
    output logic [15:0] score,
    output logic        game_over
);
    localparam int unsigned POS_W   = 12;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned VEL_W   = 8;
    localparam int unsigned SUM_W   = POS_W + 2;
    localparam int unsigned SPD_W   = $clog2(SPEED_MAX + 1);
    localparam int unsigned SCNT_W  = $clog2(SPEED_STEP + 1);
    localparam int unsigned NCNT_W  = $clog2(NIGHT_PERIOD + 1);
    localparam int unsigned ACNT_W  = $clog2(ANIM_FRAMES + 1);
    localparam int unsigned SPAWN_X = 320 + 20;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t state_q, state_nxt;

    logic [1:0]  sync_q;
    logic        btn_prev_q;
    logic        jump_pend_q;
    logic [15:0] lfsr_q;
    logic        jump_ev_c;
    logic        jump_pend_c;

    logic signed [VEL_W-1:0] vel_q, vel_nxt;
    logic                    air_q, air_nxt;
    logic [SPD_W-1:0]        speed_q, speed_nxt;
    logic [SCNT_W-1:0]       speed_cnt_q, speed_cnt_nxt;
    logic [NCNT_W-1:0]       night_cnt_q, night_cnt_nxt;
    logic [ACNT_W-1:0]       anim_cnt_q, anim_cnt_nxt;
    logic                    run_phase_q, run_phase_nxt;

    logic [POS_W-1:0]   dino_y_nxt, obstacle_x_nxt;
    logic [1:0]         dino_state_nxt;
    logic               night_nxt, game_over_nxt;
    logic [SCORE_W-1:0] score_nxt;

    logic [POS_W-1:0]        dx_c, dy_c;
    logic                    hit_c;
    logic signed [SUM_W-1:0] y_sum;
    logic                    landed;

    // Button path: two-flop synchroniser, rising-edge detect, pending until next frame
    assign jump_ev_c   = sync_q[1] & ~btn_prev_q;
    assign jump_pend_c = jump_pend_q | jump_ev_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b00;
            btn_prev_q  <= 1'b0;
            jump_pend_q <= 1'b0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            sync_q      <= {sync_q[0], jump_btn};
            btn_prev_q  <= sync_q[1];
            jump_pend_q <= frame_tick ? 1'b0 : jump_pend_c;
            lfsr_q      <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    // Collision window evaluated on the registered positions
    assign dx_c  = (obstacle_x >= POS_W'(DINO_X)) ? (obstacle_x - POS_W'(DINO_X))
                                                  : (POS_W'(DINO_X) - obstacle_x);
    assign dy_c  = POS_W'(GROUND_Y) - dino_y;
    assign hit_c = (dx_c < POS_W'(HIT_DX)) && (dy_c < POS_W'(HIT_DY));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (frame_tick) begin
            case (state_q)
                ST_IDLE: if (jump_pend_c) state_nxt = ST_RUN;
                ST_RUN:  if (hit_c)       state_nxt = ST_OVER;
                ST_OVER: if (jump_pend_c) state_nxt = ST_RUN;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dino_y_nxt     = dino_y;
        dino_state_nxt = dino_state;
        obstacle_x_nxt = obstacle_x;
        night_nxt      = night;
        score_nxt      = score;
        game_over_nxt  = game_over;
        vel_nxt        = vel_q;
        air_nxt        = air_q;
        speed_nxt      = speed_q;
        speed_cnt_nxt  = speed_cnt_q;
        night_cnt_nxt  = night_cnt_q;
        anim_cnt_nxt   = anim_cnt_q;
        run_phase_nxt  = run_phase_q;
        y_sum          = '0;
        landed         = 1'b0;

        if (frame_tick && state_q == ST_OVER && jump_pend_c) begin
            dino_y_nxt     = POS_W'(GROUND_Y);
            dino_state_nxt = 2'd0;
            obstacle_x_nxt = POS_W'(OBS_START_X);
            night_nxt      = 1'b0;
            score_nxt      = '0;
            game_over_nxt  = 1'b0;
            vel_nxt        = '0;
            air_nxt        = 1'b0;
            speed_nxt      = SPD_W'(SPEED_INIT);
            speed_cnt_nxt  = '0;
            night_cnt_nxt  = '0;
            anim_cnt_nxt   = '0;
            run_phase_nxt  = 1'b0;
        end else if (frame_tick && state_q == ST_RUN) begin
            if (hit_c) begin
                dino_state_nxt = 2'd3;
                game_over_nxt  = 1'b1;
            end else begin
                if (jump_pend_c && !air_q) begin
                    vel_nxt = -VEL_W'(JUMP_V);
                    air_nxt = 1'b1;
                end

                // Sign-extended velocity step; landing snaps to the ground line
                if (air_nxt) begin
                    y_sum = $signed({2'b00, dino_y}) + SUM_W'(vel_nxt);
                    if (y_sum >= $signed(SUM_W'(GROUND_Y))) begin
                        dino_y_nxt = POS_W'(GROUND_Y);
                        vel_nxt    = '0;
                        air_nxt    = 1'b0;
                        landed     = 1'b1;
                    end else begin
                        dino_y_nxt = y_sum[POS_W-1:0];
                        vel_nxt    = vel_nxt + VEL_W'(GRAVITY);
                    end
                end

                if (obstacle_x <= POS_W'(speed_q)) begin
                    obstacle_x_nxt = POS_W'(SPAWN_X) + POS_W'(lfsr_q[5:0]);
                    if (score != '1) score_nxt = score + SCORE_W'(1);
                    if (speed_cnt_q == SCNT_W'(SPEED_STEP - 1)) begin
                        speed_cnt_nxt = '0;
                        if (speed_q < SPD_W'(SPEED_MAX)) speed_nxt = speed_q + SPD_W'(1);
                    end else begin
                        speed_cnt_nxt = speed_cnt_q + SCNT_W'(1);
                    end
                    if (night_cnt_q == NCNT_W'(NIGHT_PERIOD - 1)) begin
                        night_cnt_nxt = '0;
                        night_nxt     = ~night;
                    end else begin
                        night_cnt_nxt = night_cnt_q + NCNT_W'(1);
                    end
                end else begin
                    obstacle_x_nxt = obstacle_x - POS_W'(speed_q);
                end

                // Leg animation only advances on ground frames; landing restarts it
                if (air_nxt) begin
                    dino_state_nxt = 2'd2;
                end else if (landed) begin
                    anim_cnt_nxt   = '0;
                    run_phase_nxt  = 1'b0;
                    dino_state_nxt = 2'd0;
                end else begin
                    if (anim_cnt_q == ACNT_W'(ANIM_FRAMES - 1)) begin
                        anim_cnt_nxt  = '0;
                        run_phase_nxt = ~run_phase_q;
                    end else begin
                        anim_cnt_nxt = anim_cnt_q + ACNT_W'(1);
                    end
                    dino_state_nxt = {1'b0, run_phase_nxt};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dino_y      <= POS_W'(GROUND_Y);
            dino_state  <= 2'd0;
            obstacle_x  <= POS_W'(OBS_START_X);
            night       <= 1'b0;
            score       <= '0;
            game_over   <= 1'b0;
            vel_q       <= '0;
            air_q       <= 1'b0;
            speed_q     <= SPD_W'(SPEED_INIT);
            speed_cnt_q <= '0;
            night_cnt_q <= '0;
            anim_cnt_q  <= '0;
            run_phase_q <= 1'b0;
        end else begin
            dino_y      <= dino_y_nxt;
            dino_state  <= dino_state_nxt;
            obstacle_x  <= obstacle_x_nxt;
            night       <= night_nxt;
            score       <= score_nxt;
            game_over   <= game_over_nxt;
            vel_q       <= vel_nxt;
            air_q       <= air_nxt;
            speed_q     <= speed_nxt;
            speed_cnt_q <= speed_cnt_nxt;
            night_cnt_q <= night_cnt_nxt;
            anim_cnt_q  <= anim_cnt_nxt;
            run_phase_q <= run_phase_nxt;
        end
    end

endmodule

// File: tb/tb_game_state_engine.sv
// Randomized bench for game_state_engine against a frame-level game model.
module tb_game_state_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        jump_btn;
    logic [11:0] dino_y;
    logic [1:0]  dino_state;
    logic [11:0] obstacle_x;
    logic        night;
    logic [15:0] score;
    logic        game_over;

    game_state_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .jump_btn   (jump_btn),
        .dino_y     (dino_y),
        .dino_state (dino_state),
        .obstacle_x (obstacle_x),
        .night      (night),
        .score      (score),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 idle, 1 run, 2 over
    int m_mode, m_y, m_v, m_ox, m_score, m_passes, m_gticks, m_dstate;
    bit m_air, m_pend;
    logic [15:0] m_lfsr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= (m_lfsr >> 1) |
                              16'((m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5]) << 15);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int m_speed();
        int s = 2 + m_passes / 8;
        return (s > 6) ? 6 : s;
    endfunction

    task automatic m_clear();
        m_y = 200; m_v = 0; m_air = 0; m_ox = 340; m_score = 0;
        m_passes = 0; m_gticks = 0; m_dstate = 0; m_pend = 0;
    endtask

    task automatic m_step();
        int dx, s;
        if (m_mode == 2) begin
            if (m_pend) begin m_clear(); m_mode = 1; end
        end else if (m_mode == 0) begin
            if (m_pend) m_mode = 1;
        end else begin
            dx = (m_ox > 40) ? m_ox - 40 : 40 - m_ox;
            if (dx < 12 && (200 - m_y) < 16) begin
                m_mode = 2; m_dstate = 3;
            end else begin
                if (m_pend && !m_air) begin m_air = 1; m_v = -10; end
                if (m_air) begin
                    if (m_y + m_v >= 200) begin
                        m_y = 200; m_v = 0; m_air = 0; m_gticks = 0;
                    end else begin
                        m_y += m_v; m_v += 1;
                    end
                end else begin
                    m_gticks++;
                end
                s = m_speed();
                if (m_ox <= s) begin
                    m_ox = 340 + int'(m_lfsr[5:0]);
                    m_passes++;
                    if (m_score < 65535) m_score++;
                end else begin
                    m_ox -= s;
                end
                m_dstate = m_air ? 2 : (m_gticks / 6) % 2;
            end
        end
        m_pend = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dino_y"},     int'(dino_y),     m_y);
        check({tag, ".dino_state"}, int'(dino_state), m_dstate);
        check({tag, ".obstacle_x"}, int'(obstacle_x), m_ox);
        check({tag, ".night"},      int'(night),      (m_passes / 16) % 2);
        check({tag, ".score"},      int'(score),      m_score);
        check({tag, ".game_over"},  int'(game_over),  (m_mode == 2) ? 1 : 0);
    endtask

    // Called aligned to a negedge; returns aligned to a negedge
    task automatic do_tick(input string tag);
        frame_tick = 1'b1;
        m_step();
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hold);
        jump_btn = 1'b1;
        idle(hold);
        jump_btn = 1'b0;
        idle(3);
        m_pend = 1;
    endtask

    function automatic bit want_jump();
        int s = m_speed();
        return (m_mode == 1) && !m_air && (m_ox - 2 * s > 51) && (m_ox - 3 * s <= 51);
    endfunction

    task automatic tick_until_window(input int budget);
        for (int i = 0; i < budget && !want_jump(); i++) begin
            do_tick("approach");
            idle($urandom_range(0, 1));
        end
    endtask

    initial begin
        bit seen16, seen32;
        rst_n = 1'b0; frame_tick = 1'b0; jump_btn = 1'b0;
        m_clear(); m_mode = 0;
        idle(3);
        check_all("reset");
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 10; i++) do_tick("idle");

        press(1);
        do_tick("start");

        // Single jump arc
        press(2);
        for (int t = 1; t <= 21; t++) begin
            do_tick("jump");
            if (t == 10) check("jump_apex", int'(dino_y), 145);
            if (t == 20) check("jump_state20", int'(dino_state), 2);
            if (t == 21) check("jump_land", int'(dino_y), 200);
        end

        // Run into the first obstacle
        for (int i = 0; i < 300 && game_over == 1'b0; i++) do_tick("to_over");
        check("over_flag", int'(game_over), 1);
        check("over_state", int'(dino_state), 3);
        check("over_x", int'(obstacle_x), 50);
        for (int i = 0; i < 20; i++) do_tick("frozen");
        check("frozen_x", int'(obstacle_x), 50);

        press(1);
        do_tick("restart");
        check("restart_x", int'(obstacle_x), 340);
        check("restart_go", int'(game_over), 0);

        // Autopilot with random gaps, glitch presses and mid-air presses
        seen16 = 0; seen32 = 0;
        for (int i = 0; i < 6000 && m_score < 40 && m_mode == 1; i++) begin
            if (want_jump()) press($urandom_range(1, 3));
            else if (m_air && $urandom_range(0, 15) == 0) press(1);
            do_tick("auto");
            if (m_score == 16 && !seen16) begin
                seen16 = 1;
                check("night_at_16", int'(night), 1);
            end
            if (m_score == 32 && !seen32) begin
                seen32 = 1;
                check("night_at_32", int'(night), 0);
            end
            idle($urandom_range(0, 2));
        end
        check("auto_score40", (score >= 16'd40) ? 1 : 0, 1);

        // Held button: one jump only
        tick_until_window(300);
        jump_btn = 1'b1;
        idle(3);
        m_pend = 1;
        for (int i = 0; i < 30; i++) do_tick("hold");
        check("hold_grounded", int'(dino_y), 200);
        jump_btn = 1'b0;
        idle(3);

        // Reset mid-jump
        tick_until_window(300);
        press(1);
        for (int i = 0; i < 5; i++) do_tick("midjump");
        rst_n = 1'b0;
        m_clear(); m_mode = 0;
        #1;
        check_all("rst_midjump");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 3; i++) do_tick("post_rst");

        // Reset from OVER
        press(1);
        do_tick("start2");
        for (int i = 0; i < 400 && m_mode != 2; i++) do_tick("to_over2");
        check("over2_flag", int'(game_over), 1);
        rst_n = 1'b0;
        m_clear(); m_mode = 0;
        #1;
        check_all("rst_over");
        idle(2);
        rst_n = 1'b1;
        idle(2);
        do_tick("post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/game_state_engine.md
Name: game_state_engine

Overview:
- Per-frame game logic for the dinosaur runner. It produces the scene state that the frame renderer consumes: dino_y, dino_state, obstacle_x and night.
- Covers jump physics, obstacle scrolling and respawn, collision detection, score, the night toggle and the idle/run/over state machine.
- Advances once per frame_tick, a one-cycle pulse issued at vertical blank by the VGA timing block. All coordinates are in 320x240 screen space.

Parameters:
- GROUND_Y, 200, screen row of the ground line; resting dino_y.
- DINO_X, 40, fixed dino centre column.
- JUMP_V, 10, initial upward speed in px/frame.
- GRAVITY, 1, speed increment per frame.
- OBS_START_X, 340, obstacle_x after reset or restart.
- SPEED_INIT, 2, initial obstacle speed in px/frame.
- SPEED_MAX, 6, speed ceiling.
- SPEED_STEP, 8, points per speed increment.
- NIGHT_PERIOD, 16, points per night toggle.
- ANIM_FRAMES, 6, frames per running-leg animation toggle.
- HIT_DX, 12, horizontal collision half-width.
- HIT_DY, 16, vertical collision height.

Ports:
- clk  in  1  system clock, also the frame_tick domain.
- rst_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- jump_btn  in  1  raw jump button, asynchronous to clk.
- dino_y  out  12  dino centre row.
- dino_state  out  2  sprite select: 0 = run A, 1 = run B, 2 = jump, 3 = dead.
- obstacle_x  out  12  obstacle centre column.
- night  out  1  1 = inverted colours.
- score  out  16  obstacles passed; saturates at 16'hFFFF.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset is asynchronous and active-low, on a single clock. All outputs are registered.
- Reset values:
  - dino_y = GROUND_Y, dino_state = 0, obstacle_x = OBS_START_X.
  - night = 0, score = 0, game_over = 0.
  - FSM = IDLE, velocity = 0, airborne = 0, speed = SPEED_INIT.
  - Animation and night counters = 0; LFSR = 16'hACE1.
- Button input:
  - jump_btn passes through a 2-flop synchroniser followed by a rising-edge detector, giving jump_ev.
  - jump_ev is held in a pending flag until the next frame_tick consumes it. Holding the button produces only one jump_ev.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. Advances every clk in every state, including IDLE and OVER.
- FSM:
  - IDLE: outputs hold. A frame_tick with a pending jump moves to RUN; no jump is performed on that tick.
  - RUN, on each frame_tick, in this order:
    - (a) Collision check on the current registered values. Hit when |obstacle_x - DINO_X| < HIT_DX and (GROUND_Y - dino_y) < HIT_DY. On a hit: go to OVER, dino_state = 3, game_over = 1, all positions frozen, no further updates this tick.
    - (b) Jump start: if a jump is pending and airborne = 0, set velocity = -JUMP_V and airborne = 1.
    - (c) Dino motion while airborne:
      - If dino_y + velocity >= GROUND_Y: dino_y = GROUND_Y, velocity = 0, airborne = 0.
      - Otherwise: dino_y += velocity, then velocity += GRAVITY.
      - velocity is signed 8-bit; the addition to dino_y uses sign extension.
    - (d) Obstacle motion:
      - If obstacle_x <= speed: respawn at obstacle_x = 320 + 20 + LFSR[5:0]. score increments (saturating). The speed and night counters advance.
      - Otherwise: obstacle_x -= speed.
    - (e) Speed: each SPEED_STEP points, speed += 1, capped at SPEED_MAX.
    - (f) Night: each NIGHT_PERIOD points, night is toggled.
    - (g) dino_state:
      - 2 while airborne.
      - Otherwise alternates 0/1 every ANIM_FRAMES ticks on the ground.
      - On landing it resumes at 0 with the animation counter cleared.
  - OVER: outputs frozen. A frame_tick with a pending jump restarts the game: everything returns to reset values except FSM = RUN. The LFSR is not reseeded.
- Timing and boundaries:
  - With no frame_tick, no state changes except the LFSR and the button synchroniser.
  - Latency: outputs update on the clk edge following the frame_tick cycle.
  - A jump pending on the same tick as a hit is discarded.
  - A jump while airborne is ignored and the pending flag is cleared.
  - A frame_tick asserted on consecutive cycles is processed each cycle.
  - Reset asserted mid-jump or in OVER returns immediately to the reset values.

Test Plan:
- Reset, then 10 frame_ticks with no button: dino_y = 200, obstacle_x = 340, state IDLE, game_over = 0, dino_state = 0.
- Start (press, 1 tick), then press again: dino_y = 190, 181, …, 145 at tick 10; 145 at tick 11; 200 at tick 21 with dino_state back to 0; dino_state = 2 during ticks 1–20.
- Start, no jumps: obstacle_x = 338, 336, …, 50 by tick 145; game_over = 1 after tick 146; dino_state = 3; obstacle_x stays 50 for a further 20 ticks.
- From OVER, press, then tick: FSM RUN, dino_y = 200, obstacle_x = 340, score = 0, night = 0, game_over = 0.
- Force clean passes (jump timed per obstacle): score increments at each respawn; speed = 3 at score 8; night = 1 at score 16 and 0 at score 32; speed stays 6 from score 32 on.
- Hold jump_btn high across 30 ticks after landing: exactly one jump; a press glitch shorter than 2 clk is never lost if held through the synchroniser.
